// File: rtl/layer_compositor.sv
// layer_compositor: two-stage VGA pixel compositor that stacks NUM_LAYERS windowed layers over a gradient.
// Optional palette cross-fade on bank switch is built when LAYER_COMPOSITOR_FADE_EN is defined.
module layer_compositor #(
  parameter int NUM_LAYERS  = 4,
  parameter int IDX_W       = 4,
  parameter int COORD_W     = 10,
  parameter int FADE_FRAMES = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [COORD_W-1:0]           DrawX,
  input  logic [COORD_W-1:0]           DrawY,
  input  logic [IDX_W-1:0]             idx_in,
  input  logic [24*(NUM_LAYERS-1)-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic                         bank_req,
  input  logic                         cfg_we,
  input  logic [7:0]                   cfg_addr,
  input  logic [23:0]                  cfg_wdata,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B,
  output logic                         out_valid,
  output logic                         fade_busy
);

  localparam int PAL_N = 1 << IDX_W;

  // Configuration registers
  logic [23:0] pal_q [2][PAL_N];
  logic [11:0] wx0_q [NUM_LAYERS];
  logic [11:0] wx1_q [NUM_LAYERS];
  logic [11:0] wy0_q [NUM_LAYERS];
  logic [11:0] wy1_q [NUM_LAYERS];
  logic [23:0] key_q;

  // NOTE: the palette is a small register file, not a RAM macro, so it can be cleared by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < PAL_N; i++)
          pal_q[b][i] <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        wx0_q[l] <= '1;
        wx1_q[l] <= '0;
        wy0_q[l] <= '1;
        wy1_q[l] <= '0;
      end
      key_q <= 24'hFFFFFF;
    end else if (cfg_we) begin
      for (int i = 0; i < PAL_N; i++)
        if (cfg_addr[7:5] == 3'b000 && cfg_addr[3:0] == 4'(i))
          pal_q[cfg_addr[4]][i] <= cfg_wdata;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (cfg_addr == 8'(8'h40 + 2 * l)) begin
          wx0_q[l] <= cfg_wdata[11:0];
          wx1_q[l] <= cfg_wdata[23:12];
        end
        if (cfg_addr == 8'(8'h41 + 2 * l)) begin
          wy0_q[l] <= cfg_wdata[11:0];
          wy1_q[l] <= cfg_wdata[23:12];
        end
      end
      if (cfg_addr == 8'h60)
        key_q <= cfg_wdata;
    end
  end

  // Bank / fade state; it only moves on frame_start so a whole frame shares one blend.
  logic cur_bank_q, cur_bank_d;

`ifdef LAYER_COMPOSITOR_FADE_EN
  localparam int FW = $clog2(FADE_FRAMES);
  localparam int AW = 8 + FW + 1;
  localparam logic [FW:0] W_FULL = (FW + 1)'(FADE_FRAMES);
  localparam logic [FW:0] W_LAST = (FW + 1)'(FADE_FRAMES - 1);

  logic [FW:0] w_q, w_d;
  logic        busy_q, busy_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_d        = w_q;
    busy_d     = busy_q;
    cur_bank_d = cur_bank_q;
    if (frame_start) begin
      if (busy_q) begin
        if (w_q == W_LAST) begin
          cur_bank_d = ~cur_bank_q;
          w_d        = '0;
          busy_d     = 1'b0;
        end else begin
          w_d = w_q + 1'b1;
        end
      end else if (bank_req != cur_bank_q) begin
        w_d    = (FW + 1)'(1);
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_bank_q <= 1'b0;
      w_q        <= '0;
      busy_q     <= 1'b0;
    end else begin
      cur_bank_q <= cur_bank_d;
      w_q        <= w_d;
      busy_q     <= busy_d;
    end
  end

  assign fade_busy = busy_q;

  // Truncating per-channel blend: (old*(F-w) + new*w) >> log2(F).
  function automatic logic [7:0] blend(input logic [7:0] old_c, input logic [7:0] new_c,
                                       input logic [FW:0] w);
    logic [AW-1:0] acc;
    acc = AW'(old_c) * AW'(W_FULL - w) + AW'(new_c) * AW'(w);
    return 8'(acc >> FW);
  endfunction
`else
  always_comb begin
    cur_bank_d = cur_bank_q;
    if (frame_start && bank_req != cur_bank_q)
      cur_bank_d = ~cur_bank_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) cur_bank_q <= 1'b0;
    else       cur_bank_q <= cur_bank_d;
  end

  assign fade_busy = 1'b0;
`endif

  // Stage 1: window hits, palette reads of both banks, operand capture
  logic [11:0]                  dx_c, dy_c;
  logic [NUM_LAYERS-1:0]        hit_d;
  logic                         v1_q;
  logic [6:0]                   bgx1_q;
  logic [23:0]                  p0_q, p1_q;
  logic [24*(NUM_LAYERS-1)-1:0] rgb1_q;
  logic [NUM_LAYERS-1:0]        en1_q, hit1_q;

  assign dx_c = 12'(DrawX);
  assign dy_c = 12'(DrawY);

  always_comb begin
    hit_d = '0;
    for (int l = 0; l < NUM_LAYERS; l++)
      hit_d[l] = (dx_c >= wx0_q[l]) && (dx_c <= wx1_q[l]) &&
                 (dy_c >= wy0_q[l]) && (dy_c <= wy1_q[l]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1_q   <= 1'b0;
      bgx1_q <= '0;
      p0_q   <= '0;
      p1_q   <= '0;
      rgb1_q <= '0;
      en1_q  <= '0;
      hit1_q <= '0;
    end else begin
      v1_q   <= pix_valid;
      bgx1_q <= DrawX[9:3];
      p0_q   <= pal_q[0][idx_in];
      p1_q   <= pal_q[1][idx_in];
      rgb1_q <= layer_rgb;
      en1_q  <= layer_en;
      hit1_q <= hit_d;
    end
  end

  // Stage 2: blend, priority resolve, output register
  logic [23:0] old_c, l0_c, bg_c, col_d;
  logic [23:0] rgb_q;
  logic        v2_q;
`ifdef LAYER_COMPOSITOR_FADE_EN
  logic [23:0] new_c;
`endif

  always_comb begin
    old_c = cur_bank_q ? p1_q : p0_q;
`ifdef LAYER_COMPOSITOR_FADE_EN
    new_c = cur_bank_q ? p0_q : p1_q;
    l0_c  = {blend(old_c[23:16], new_c[23:16], w_q),
             blend(old_c[15:8],  new_c[15:8],  w_q),
             blend(old_c[7:0],   new_c[7:0],   w_q)};
`else
    l0_c  = old_c;
`endif
    bg_c  = {8'hFF - {1'b0, bgx1_q} - 8'd60,
             8'hD8 - {1'b0, bgx1_q} - 8'd60,
             8'h9B};
    col_d = bg_c;
    if (en1_q[0] && hit1_q[0])
      col_d = l0_c;
    // Later layers override earlier ones; key-coloured pixels fall through.
    for (int l = 1; l < NUM_LAYERS; l++)
      if (en1_q[l] && hit1_q[l] && rgb1_q[24*(l-1) +: 24] != key_q)
        col_d = rgb1_q[24*(l-1) +: 24];
    if (!v1_q)
      col_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v2_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      v2_q  <= v1_q;
      rgb_q <= col_d;
    end
  end

  assign out_valid = v2_q;
  assign VGA_R     = rgb_q[23:16];
  assign VGA_G     = rgb_q[15:8];
  assign VGA_B     = rgb_q[7:0];

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: background, windows, priority/key, bank switch and reset.
module tb_layer_compositor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX, DrawY;
  logic [3:0]  idx_in;
  logic [71:0] layer_rgb;
  logic [3:0]  layer_en;
  logic        bank_req;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [23:0] cfg_wdata;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        out_valid;
  logic        fade_busy;

  int vectors = 0;
  int errs    = 0;

  layer_compositor dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .idx_in     (idx_in),
    .layer_rgb  (layer_rgb),
    .layer_en   (layer_en),
    .bank_req   (bank_req),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .out_valid  (out_valid),
    .fade_busy  (fade_busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] a, input logic [23:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic [3:0] idx);
    pix_valid = 1'b1; DrawX = 10'(x); DrawY = 10'(y); idx_in = idx;
    tick(2);
  endtask

  task automatic frame(input int n = 1);
    repeat (n) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
    tick(2);
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic layer0_setup();
    cfg(8'h40, {12'd470, 12'd170});
    cfg(8'h41, {12'd329, 12'd31});
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b1; DrawX = '0; DrawY = '0;
    idx_in = '0; layer_rgb = '0; layer_en = '0; bank_req = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick(2);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_rgb",   rgb(), 32'h000000);
    check("reset_busy",  {31'd0, fade_busy}, 32'd0);
    Reset = 1'b0;

    // Background gradient
    pix(0, 0, 4'd0);
    check("bg_x0_valid", {31'd0, out_valid}, 32'd1);
    check("bg_x0",       rgb(), 32'hC39C9B);
    pix(640, 0, 4'd0);
    check("bg_x640",     rgb(), 32'h734C9B);
    pix_valid = 1'b0;
    tick(2);
    check("invalid_valid", {31'd0, out_valid}, 32'd0);
    check("invalid_rgb",   rgb(), 32'h000000);

    // Palette, layer-0 window and its inclusive bounds
    cfg(8'h02, 24'h141212);
    cfg(8'h20, 24'h00FF00);
    layer0_setup();
    layer_en = 4'b0001;
    pix(200, 100, 4'd2);
    check("l0_hit",      rgb(), 32'h141212);
    pix(471, 100, 4'd2);
    check("l0_x1_plus1", rgb(), 32'h89629B);
    pix(170, 31, 4'd2);
    check("l0_corner_lo", rgb(), 32'h141212);
    pix(470, 329, 4'd2);
    check("l0_corner_hi", rgb(), 32'h141212);
    pix(169, 100, 4'd2);
    check("l0_x0_minus1", rgb(), 32'hAE879B);
    pix(200, 100, 4'd0);
    check("unmapped_write", rgb(), 32'h000000);
    layer_en = 4'b0000;
    pix(200, 100, 4'd2);
    check("l0_disabled", rgb(), 32'hAA839B);

    // Priority and transparency key
    cfg(8'h44, {12'd300, 12'd100});
    cfg(8'h45, {12'd150, 12'd50});
    layer_en  = 4'b0101;
    layer_rgb = {24'h000000, 24'h112233, 24'h000000};
    pix(200, 100, 4'd2);
    check("l2_over_l0", rgb(), 32'h112233);
    layer_rgb = {24'h000000, 24'hFFFFFF, 24'h000000};
    pix(200, 100, 4'd2);
    check("l2_keyed", rgb(), 32'h141212);
    cfg(8'h60, 24'h112233);
    pix(200, 100, 4'd2);
    check("new_key_old_shown", rgb(), 32'hFFFFFF);
    layer_rgb = {24'hABCDEF, 24'h112233, 24'h000000};
    layer_en  = 4'b1101;
    pix(200, 100, 4'd2);
    check("new_key_hidden_l3_empty", rgb(), 32'h141212);

    // Bank switching
    layer_en = 4'b0001;
    cfg(8'h10, 24'hFFFFFF);
    pix(200, 100, 4'd0);
    check("bank0_idx0", rgb(), 32'h000000);
    frame();
    check("no_req_busy", {31'd0, fade_busy}, 32'd0);
    bank_req = 1'b1;
`ifdef LAYER_COMPOSITOR_FADE_EN
    frame();
    check("fade_w1",      rgb(), 32'h0F0F0F);
    check("fade_w1_busy", {31'd0, fade_busy}, 32'd1);
    frame(7);
    check("fade_w8",      rgb(), 32'h7F7F7F);
    check("fade_w8_busy", {31'd0, fade_busy}, 32'd1);
    bank_req = 1'b0;
    frame(7);
    check("fade_w15", rgb(), 32'hEFEFEF);
    bank_req = 1'b1;
    frame();
    check("fade_done",      rgb(), 32'hFFFFFF);
    check("fade_done_busy", {31'd0, fade_busy}, 32'd0);
    frame();
    check("fade_idle", rgb(), 32'hFFFFFF);
    bank_req = 1'b0;
    frame(2);
    bank_req = 1'b1;
    frame(3);
    check("fade_back_w5",      rgb(), 32'hAFAFAF);
    check("fade_back_w5_busy", {31'd0, fade_busy}, 32'd1);
`else
    frame();
    check("switch_bank1", rgb(), 32'hFFFFFF);
    check("switch_busy",  {31'd0, fade_busy}, 32'd0);
    frame();
    check("switch_stays", rgb(), 32'hFFFFFF);
    bank_req = 1'b0;
    frame();
    check("switch_back", rgb(), 32'h000000);
    bank_req = 1'b1;
    frame();
    check("switch_again", rgb(), 32'hFFFFFF);
`endif

    // Reset mid-frame / mid-fade, with frame_start colliding
    Reset = 1'b1; frame_start = 1'b1;
    tick();
    Reset = 1'b0; frame_start = 1'b0; bank_req = 1'b0;
    check("rst_busy",   {31'd0, fade_busy}, 32'd0);
    check("rst_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    check("rst_valid1", {31'd0, out_valid}, 32'd0);
    tick();
    check("rst_valid2", {31'd0, out_valid}, 32'd1);
    check("rst_palette_cleared", rgb(), 32'hAA839B);
    cfg(8'h00, 24'h224466);
    cfg(8'h10, 24'hFFFFFF);
    layer0_setup();
    pix(200, 100, 4'd0);
    check("rst_bank0_colour", rgb(), 32'h224466);
    check("rst_bank0_busy",   {31'd0, fade_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised, pipelined pixel compositor that generates the VGA RGB output for the music player display. It stacks NUM_LAYERS rectangular layers over the gradient background, using programmable windows and a transparency key. Layer 0 is an indexed cover-art layer backed by a two-bank palette, and a bank switch (song change) cross-fades over a configurable number of frames. It sits between the layer sprite/ROM readers and the VGA controller, which supplies DrawX/DrawY.

## Interface
- NUM_LAYERS, 4: total layers (2..8); layer 0 is indexed, layers 1..NUM_LAYERS-1 are direct RGB.
- IDX_W, 4: palette index width; each bank has 2^IDX_W entries (IDX_W ≤ 4).
- COORD_W, 10: DrawX/DrawY width (10..12).
- FADE_FRAMES, 16: cross-fade length in frames (power of two, 2..256).

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pix_valid  in  1  current DrawX/DrawY is a visible pixel.
- DrawX, DrawY  in  COORD_W  current pixel coordinates.
- idx_in  in  IDX_W  layer-0 palette index for the current pixel.
- layer_rgb  in  24*(NUM_LAYERS-1)  RGB for layers 1..N-1; layer L is at bits [24L-1 : 24(L-1)].
- layer_en  in  NUM_LAYERS  per-layer enable.
- bank_req  in  1  requested palette bank (level).
- cfg_we  in  1  config write strobe.
- cfg_addr  in  8  config address.
- cfg_wdata  in  24  config data.
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour.
- out_valid  out  1  pix_valid delayed by 2 cycles.
- fade_busy  out  1  cross-fade in progress.

## Operation
- Config map:
  - 0x00–0x1F: palette entry; bank = addr[4], index = addr[3:0] (indices ≥ 2^IDX_W are ignored).
  - 0x40+2L: X window of layer L, {x1[23:12], x0[11:0]}.
  - 0x41+2L: Y window of layer L, same packing.
  - 0x60: key colour.
  - Writes to unmapped addresses are ignored.
- Window hit: x0 ≤ DrawX ≤ x1 and y0 ≤ DrawY ≤ y1, inclusive. x0 > x1 or y0 > y1 means the window is empty.
- Winner: the highest-numbered layer L that is enabled and hit and, for L ≥ 1, has layer_rgb ≠ key. If no layer wins, the pixel is background.
- Layer 0 colour: the palette of the active bank (cur_bank), blended during a fade as described below.
- Background: R = 0xFF − {1'b0,DrawX[9:3]} − 60, G = 0xD8 − {1'b0,DrawX[9:3]} − 60, B = 0x9B. All arithmetic is modulo 256.
- Outputs are 0 whenever out_valid = 0.
- Fade state: cur_bank and weight w (0..FADE_FRAMES). w changes only on frame_start, so each frame uses a single blend.
  - On frame_start with fade_busy = 0 and bank_req ≠ cur_bank: set w = 1 and fade_busy = 1.
  - On frame_start while busy: w = w + 1. When w reaches FADE_FRAMES, instead flip cur_bank, set w = 0 and clear fade_busy.
  - bank_req changes during a fade are ignored; bank_req is re-sampled at the first frame_start after completion.
- Blend, per channel: (old·(F−w) + new·w) >> log2(F), where old is the cur_bank entry and new is the other bank's entry.
  - The intermediate is 8+log2(F)+1 bits; the result is truncated, not rounded.
- Reset values:
  - Palettes: 0.
  - All windows: x0 = y0 = all ones, x1 = y1 = 0 (empty).
  - Key: 0xFFFFFF.
  - cur_bank = 0, w = 0, fade_busy = 0.
  - out_valid and VGA_R/G/B: 0.

## Timing
- Pipeline stage 1 registers coordinates, index, RGB, enables and window hits, and performs the palette reads for both banks.
- Stage 2 blends, resolves priority and registers RGB.
- Latency is exactly 2 cycles, one pixel per cycle, with no stalls.
- A config write in cycle n is visible to the pixel that enters stage 1 in cycle n+1.
- Simultaneous frame_start and config write: both take effect.
- Simultaneous frame_start and Reset: Reset wins.
- Reset mid-frame or mid-fade: all state returns to reset values on the next edge, and out_valid is 0 for 2 cycles.

## Configuration
- LAYER_COMPOSITOR_FADE_EN:
  - Defined: cross-fade as described above.
  - Undefined: on frame_start with bank_req ≠ cur_bank, cur_bank flips immediately. No blend multipliers are built, w is absent and fade_busy is tied to 0.

## Test plan
- Background after reset: Reset, pix_valid = 1, DrawX = 0 → two cycles later RGB = 0xC3/0x9C/0x9B. With DrawX = 640, R = 0x73.
- Palette and window: write 0x02 = 0x141212, set layer-0 windows X 170..470 and Y 31..329, enable layer 0, drive pixel (200,100) with idx = 2 → 0x141212. Pixel (471,100) → background.
- Priority and key: layers 0 and 2 overlap and both are enabled.
  - Layer 2 rgb = 0x112233 → output 0x112233.
  - Layer 2 rgb = key 0xFFFFFF → layer-0 colour is shown.
- Fade (FADE_EN, F = 16): bank0 idx0 = 0x000000, bank1 idx0 = 0xFFFFFF, bank_req = 1.
  - After 8 frame_starts → 0x7F7F7F with fade_busy = 1.
  - After 16 frame_starts → 0xFFFFFF, fade_busy = 0, cur_bank = 1.
- Reset mid-fade: assert Reset at w = 5 → fade_busy = 0, bank 0 colour after reset, out_valid = 0 for 2 cycles.
- No FADE_EN: set bank_req = 1, pulse frame_start → the next frame shows the bank1 colour directly and fade_busy stays 0.
